// File: rtl/div16u8u_seq_pkg.sv
// div_pkg: shared definitions for the sequential restoring divider.
//   - FSM state encoding (IDLE / BUSY / DONE) as plain 2-bit constants
//   - cnt_width(): width of the iteration counter for a given operand width
package div_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_BUSY = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    // Counter must index iterations 0..W-1; keep at least one bit for W=1.
    function automatic int unsigned cnt_width(input int unsigned w);
        if (w > 32'd1) begin
            return $clog2(w);
        end else begin
            return 32'd1;
        end
    endfunction

endpackage

// File: rtl/div16u8u_seq_restore_step.sv
// div_restore_step: one combinational restoring-division step.
//   rem_i  [W-1:0]  current partial remainder (always < div_i)
//   bit_i           next dividend bit shifted in at the LSB
//   div_i  [W-1:0]  divisor
//   rem_o  [W-1:0]  next partial remainder
//   q_o             quotient bit produced by this step
module div_restore_step #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] rem_i,
    input  logic         bit_i,
    input  logic [W-1:0] div_i,
    output logic [W-1:0] rem_o,
    output logic         q_o
);

    logic [W:0]   trial_s;
    logic [W-1:0] diff_s;

    assign trial_s = {rem_i, bit_i};
    // The true difference is below 2^W whenever it is kept, so the low W bits
    // of a modular subtraction are exact.
    assign diff_s  = trial_s[W-1:0] - div_i;

    // Restore (keep the trial value) when the divisor does not fit.
    always_comb begin
        if (trial_s >= {1'b0, div_i}) begin
            rem_o = diff_s;
            q_o   = 1'b1;
        end else begin
            rem_o = trial_s[W-1:0];
            q_o   = 1'b0;
        end
    end

endmodule

// File: rtl/div16u8u_seq.sv
// div16u8u_seq: sequential unsigned divider, 2W-bit dividend / W-bit divisor,
// one quotient bit per clock, behind valid/ready handshakes.
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operand handshake (A: 2W bits, B: W bits)
//   out_valid / out_ready result handshake
//   Q, R                  quotient and remainder (W bits each)
//   ovf                   quotient does not fit in W bits (includes B==0)
//   dz                    divisor was zero
module div16u8u_seq
    import div_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*W-1:0] A,
    input  logic [W-1:0]   B,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   Q,
    output logic [W-1:0]   R,
    output logic           ovf,
    output logic           dz
);

    localparam int unsigned CW = cnt_width(W);
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    state_t        state_q,     state_d;
    logic [CW-1:0] cnt_q,       cnt_d;
    logic [W-1:0]  rem_q,       rem_d;
    logic [W-1:0]  dvd_q,       dvd_d;
    logic [W-1:0]  div_q,       div_d;
    logic [W-1:0]  quo_q,       quo_d;
    logic          ovf_q,       ovf_d;
    logic          dz_q,        dz_d;
    logic          in_ready_q,  in_ready_d;
    logic          out_valid_q, out_valid_d;

    logic [W-1:0]  step_rem_s;
    logic          step_q_s;
    logic [W-1:0]  a_hi_s;
    logic [W-1:0]  a_lo_s;

    assign a_hi_s = A[2*W-1:W];
    assign a_lo_s = A[W-1:0];

    div_restore_step #(.W(W)) u_step (
        .rem_i (rem_q),
        .bit_i (dvd_q[W-1]),
        .div_i (div_q),
        .rem_o (step_rem_s),
        .q_o   (step_q_s)
    );

    // Next-state logic: accept + error check, iteration, result handshake.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        dvd_d       = dvd_q;
        div_d       = div_q;
        quo_d       = quo_q;
        ovf_d       = ovf_q;
        dz_d        = dz_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    div_d      = B;
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
                    if (B == {W{1'b0}}) begin
                        state_d     = ST_DONE;
                        quo_d       = {W{1'b1}};
                        rem_d       = a_lo_s;
                        ovf_d       = 1'b1;
                        dz_d        = 1'b1;
                        out_valid_d = 1'b1;
                    end else if (a_hi_s >= B) begin
                        state_d     = ST_DONE;
                        quo_d       = {W{1'b1}};
                        rem_d       = {W{1'b0}};
                        ovf_d       = 1'b1;
                        dz_d        = 1'b0;
                        out_valid_d = 1'b1;
                    end else begin
                        state_d = ST_BUSY;
                        rem_d   = a_hi_s;
                        dvd_d   = a_lo_s;
                        quo_d   = {W{1'b0}};
                        ovf_d   = 1'b0;
                        dz_d    = 1'b0;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                rem_d = step_rem_s;
                dvd_d = {dvd_q[W-2:0], 1'b0};
                quo_d = {quo_q[W-2:0], step_q_s};
                if (cnt_q == CNT_LAST) begin
                    cnt_d       = '0;
                    state_d     = ST_DONE;
                    out_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                cnt_d       = '0;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            dvd_q       <= '0;
            div_q       <= '0;
            quo_q       <= '0;
            ovf_q       <= 1'b0;
            dz_q        <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            dvd_q       <= dvd_d;
            div_q       <= div_d;
            quo_q       <= quo_d;
            ovf_q       <= ovf_d;
            dz_q        <= dz_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign Q         = quo_q;
    assign R         = rem_q;
    assign ovf       = ovf_q;
    assign dz        = dz_q;

endmodule
